// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode stage with registered valid/ready output and flush.
// Define DECODE_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
package opcodes;
  typedef enum logic [6:0] {
    LOAD      = 7'b0000011,
    LOAD_FP   = 7'b0000111,
    CUSTOM_0  = 7'b0001011,
    MISC_MEM  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    AUIPC     = 7'b0010111,
    OP_IMM_32 = 7'b0011011,
    STORE     = 7'b0100011,
    STORE_FP  = 7'b0100111,
    CUSTOM_1  = 7'b0101011,
    AMO       = 7'b0101111,
    OP        = 7'b0110011,
    LUI       = 7'b0110111,
    OP_32     = 7'b0111011,
    MADD      = 7'b1000011,
    MSUB      = 7'b1000111,
    NMSUB     = 7'b1001011,
    NMADD     = 7'b1001111,
    OP_FP     = 7'b1010011,
    CUSTOM_2  = 7'b1011011,
    BRANCH    = 7'b1100011,
    JALR      = 7'b1100111,
    JAL       = 7'b1101111,
    SYSTEM    = 7'b1110011,
    CUSTOM_3  = 7'b1111011
  } opcode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_imm;
    logic        illegal;
  } bundle_t;
endpackage

module decode_stage import opcodes::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_alu_imm,
  output logic            out_illegal
);
  bundle_t dec, out_q;
  logic accept;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign accept = in_valid && in_ready;

  // Every legal opcode ends in 2'b11, so compressed encodings fall into the default arm.
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.opcode   = in_inst[6:0];
    dec.funct3   = in_inst[14:12];
    dec.funct7b5 = in_inst[30];
    dec.rd       = in_inst[11:7];
    dec.rs1      = in_inst[19:15];
    dec.rs2      = in_inst[24:20];
    dec.alu_imm  = 1'b1;
    case (in_inst[6:0])
      LOAD:             begin dec.imm = imm_i; dec.reg_write = 1'b1; dec.mem_read = 1'b1; end
      OP_IMM:           begin dec.imm = imm_i; dec.reg_write = 1'b1; end
      MISC_MEM, SYSTEM: dec.imm = imm_i;
      JALR:             begin dec.imm = imm_i; dec.reg_write = 1'b1; dec.jump = 1'b1; end
      STORE:            begin dec.imm = imm_s; dec.mem_write = 1'b1; end
      BRANCH:           begin dec.imm = imm_b; dec.branch = 1'b1; dec.alu_imm = 1'b0; end
      LUI, AUIPC:       begin dec.imm = imm_u; dec.reg_write = 1'b1; end
      JAL:              begin dec.imm = imm_j; dec.reg_write = 1'b1; dec.jump = 1'b1; end
      OP:               begin dec.reg_write = 1'b1; dec.alu_imm = 1'b0; end
      default:          begin dec.illegal = 1'b1; dec.alu_imm = 1'b0; end
    endcase
    dec.reg_write = dec.reg_write && (dec.rd != 5'd0);
  end

`ifdef DECODE_SKID_EN
  bundle_t skid_q;
  logic skid_valid;

  assign in_ready = !skid_valid;

  // The skid entry only fills while the output register is stalled, so it always drains first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) out_q <= skid_q;
      else if (accept) out_q <= dec;
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= accept;
      if (accept) out_q <= dec;
    end
  end
`endif

  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.opcode;
  assign out_funct3    = out_q.funct3;
  assign out_funct7b5  = out_q.funct7b5;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_reg_write = out_q.reg_write;
  assign out_mem_read  = out_q.mem_read;
  assign out_mem_write = out_q.mem_write;
  assign out_branch    = out_q.branch;
  assign out_jump      = out_q.jump;
  assign out_alu_imm   = out_q.alu_imm;
  assign out_illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized bench for decode_stage against a queue-based reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;
  logic in_ready, out_valid, out_funct7b5;
  logic [31:0] out_pc, out_imm;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_imm, out_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_alu_imm(out_alu_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

`ifdef DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // flags = {reg_write, mem_read, mem_write, branch, jump, alu_imm, illegal}
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  flags;
  } bundle_t;

  bundle_t act, m;
  logic [6:0] fl;
  bundle_t q[$];
  bit live = 0, zero_exp = 1;
  int checks = 0, errors = 0;
  logic [6:0] ops [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B};

  assign fl  = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_imm, out_illegal};
  assign act = {out_pc, out_opcode, out_funct3, out_funct7b5, out_rd, out_rs1, out_rs2, out_imm, fl};

  function automatic bundle_t model(input logic [31:0] pc, input logic [31:0] inst);
    bundle_t b;
    logic [31:0] hi;
    int fmt;
    logic rw, mr, mw, br, jp, legal;
    hi = {32{inst[31]}};
    fmt = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; legal = 1;
    case (inst[6:0])
      7'h03: begin fmt = 1; rw = 1; mr = 1; end
      7'h0F: fmt = 1;
      7'h13: begin fmt = 1; rw = 1; end
      7'h17: begin fmt = 4; rw = 1; end
      7'h23: begin fmt = 2; mw = 1; end
      7'h33: rw = 1;
      7'h37: begin fmt = 4; rw = 1; end
      7'h63: begin fmt = 3; br = 1; end
      7'h67: begin fmt = 1; rw = 1; jp = 1; end
      7'h6F: begin fmt = 5; rw = 1; jp = 1; end
      7'h73: fmt = 1;
      default: legal = 0;
    endcase
    b.pc = pc; b.opcode = inst[6:0]; b.funct3 = inst[14:12]; b.f7 = inst[30];
    b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
    case (fmt)
      1: b.imm = (hi << 11) | 32'(inst[30:20]);
      2: b.imm = (hi << 11) | (32'(inst[30:25]) << 5) | 32'(inst[11:7]);
      3: b.imm = (hi << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      4: b.imm = inst & 32'hFFFFF000;
      5: b.imm = (hi << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      default: b.imm = '0;
    endcase
    b.flags = {rw && inst[11:7] != 5'd0, mr, mw, br, jp,
               legal && inst[6:0] != 7'h33 && inst[6:0] != 7'h63, !legal};
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Compare DUT against the model, then advance the model to the state after the coming edge.
  always @(negedge clk) begin
    logic exp_ready;
    if (live) begin
      exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      if (q.size() != 0 || zero_exp) begin
        checks++;
        if (act !== (q.size() != 0 ? q[0] : bundle_t'('0))) begin
          errors++;
          $display("FAIL bundle got %h expected %h", act, q.size() != 0 ? q[0] : bundle_t'('0));
        end
      end
      if (reset) begin
        q.delete();
        zero_exp = 1;
      end else if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          q.push_back(model(in_pc, in_inst));
          zero_exp = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1; in_pc = pc; in_inst = inst;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int acc;
    m = model(32'h0, 32'hFFDFF06F);
    chk("model jal imm", m.imm, 32'hFFFFFFFC);
    m = model(32'h0, 32'hFE000EE3);
    chk("model beq imm", m.imm, 32'hFFFFFFFC);
    m = model(32'h0, 32'h0020A423);
    chk("model sw imm", m.imm, 32'h8);
    chk("model sw flags", 32'(m.flags), 32'b0010010);
    cycles(3);
    reset = 0; live = 1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    send(32'h100, 32'h00500093);
    chk("addi valid", 32'(out_valid), 1);
    chk("addi opcode", 32'(out_opcode), 32'h13);
    chk("addi rd", 32'(out_rd), 1);
    chk("addi imm", out_imm, 32'h5);
    chk("addi pc", out_pc, 32'h100);
    chk("addi flags", 32'(fl), 32'b1000010);
    send(32'h104, 32'h0020A423);
    chk("sw rs1", 32'(out_rs1), 1);
    chk("sw rs2", 32'(out_rs2), 2);
    chk("sw imm", out_imm, 32'h8);
    chk("sw flags", 32'(fl), 32'b0010010);
    send(32'h108, 32'hFE000EE3);
    chk("beq imm", out_imm, 32'hFFFFFFFC);
    chk("beq flags", 32'(fl), 32'b0001000);
    send(32'h10C, 32'h123452B7);
    chk("lui imm", out_imm, 32'h12345000);
    chk("lui flags", 32'(fl), 32'b1000010);
    send(32'h110, 32'h00000037);
    chk("lui x0 flags", 32'(fl), 32'b0000010);
    send(32'h114, 32'h0000000B);
    chk("custom0 valid", 32'(out_valid), 1);
    chk("custom0 flags", 32'(fl), 32'b0000001);
    send(32'h118, 32'h00000001);
    chk("rvc flags", 32'(fl), 32'b0000001);
    cycles(2);
    // Stall with back-to-back offers, then drain.
    out_ready = 0; acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = (acc < 3); in_pc = 32'h200 + 32'(acc) * 4;
      in_inst = (acc == 0) ? 32'h00500093 : (acc == 1) ? 32'h0020A423 : 32'h123452B7;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("stall accepts", 32'(acc), 32'(CAP));
    out_ready = 1;
    cycles(3);
    // Fill during a stall, then flush.
    out_ready = 0; in_valid = 1; in_inst = 32'h00A00113; in_pc = 32'h300;
    cycles(2);
    in_valid = 0; flush = 1;
    cycles(1);
    flush = 0;
    chk("flush valid", 32'(out_valid), 0);
    out_ready = 1;
    cycles(1);
    chk("flush skid gone", 32'(out_valid), 0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      in_inst = ins; in_pc = $urandom();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    flush = 0; reset = 0;
    // Reset mid-stall.
    out_ready = 0; in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h400;
    cycles(2);
    reset = 1; in_valid = 0;
    cycles(1);
    reset = 0;
    chk("reset valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset imm", out_imm, 0);
    chk("reset pc", out_pc, 0);
    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
